// File: rtl/multicell_mem_pkg.sv
`default_nettype none
// ============================================================================
// multicell_mem_pkg : shared state type and lane helpers for multicell_mem
// Revision: 1.0
// ============================================================================
package multicell_mem_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   function automatic logic [31:0] size_to_count(input logic [31:0] sz);
      return sz + 32'd1;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [31:0] sz, input int lanes);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         m[i] = (i < lanes) && (32'(i) <= sz);
      end
      return m;
   endfunction

   function automatic logic [31:0] cell_index(input logic [31:0] addr, input logic [31:0] lane,
                                              input int log2_cells);
      return (addr + lane) & ((32'd1 << log2_cells) - 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicell_mem_clear_seq.sv
`default_nettype none
// ============================================================================
// mem_clear_seq : CLEAR/IDLE sequencer that walks every cell once after reset
// Revision: 1.0
// ============================================================================
module mem_clear_seq
   import multicell_mem_pkg::*;
#(
   parameter int LOG2_CELLS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  clr_we_o,
   output logic [LOG2_CELLS-1:0] clr_idx_o,
   output logic                  ready_o
);

   localparam logic [LOG2_CELLS-1:0] IDX_ONE = 1;

   state_e                state_q, state_d;
   logic [LOG2_CELLS-1:0] idx_q, idx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      clr_we_o = 1'b0;
      ready_o  = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_we_o = 1'b1;
            idx_d    = idx_q + IDX_ONE;
            // The edge that zeroes the last cell is the one that leaves CLEAR.
            if (&idx_q) state_d = IDLE;
         end
         IDLE:    ready_o = 1'b1;
         default: state_d = CLEAR;
      endcase
   end

   assign clr_idx_o = idx_q;

endmodule
`default_nettype wire

// File: rtl/multicell_mem.sv
`default_nettype none
// ============================================================================
// multicell_mem : byte-cell RAM, 1..LANES cells per access, registered read.
// Optional alignment/range rejection: define MULTICELL_MEM_ALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
module multicell_mem
   import multicell_mem_pkg::*;
#(
   parameter int LOG2_CELLS = 8,
   parameter int ADDR_SIZE  = 32,
   parameter int CELL_SIZE  = 8,
   parameter int LANES      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_SIZE-1:0]         addr_bus,
   input  logic [$clog2(LANES)-1:0]     size,
   input  logic [LANES*CELL_SIZE-1:0]   data_bus_in,
   input  logic                         we,
   input  logic                         re,
   output logic [LANES*CELL_SIZE-1:0]   data_bus_out,
   output logic                         rd_valid,
   output logic                         ready,
   output logic                         busy,
   output logic                         err
);

   localparam int NUM_CELLS = 1 << LOG2_CELLS;
   localparam int WORD      = LANES * CELL_SIZE;

   logic [CELL_SIZE-1:0]  mem_q [NUM_CELLS];
   logic                  clr_we;
   logic [LOG2_CELLS-1:0] clr_idx;
   logic                  seq_ready;

   logic [LOG2_CELLS-1:0] addr_lo;
   logic                  unused_addr_hi;
   logic [LANES-1:0]      lane_en;
   logic [LOG2_CELLS-1:0] lane_idx [LANES];
   logic                  accept;
   logic                  wr_fire;
   logic                  rd_fire;
   logic [WORD-1:0]       rd_data_d;
   logic [WORD-1:0]       rd_data_q;
   logic                  rd_valid_q;

   mem_clear_seq #(
      .LOG2_CELLS (LOG2_CELLS)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .clr_we_o  (clr_we),
      .clr_idx_o (clr_idx),
      .ready_o   (seq_ready)
   );

   assign addr_lo        = addr_bus[LOG2_CELLS-1:0];
   assign unused_addr_hi = ^addr_bus[ADDR_SIZE-1:LOG2_CELLS];
   assign lane_en        = LANES'(lane_mask(32'(size), LANES));

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_idx[i] = LOG2_CELLS'(cell_index(32'(addr_lo), 32'(i), LOG2_CELLS));
   end

`ifdef MULTICELL_MEM_ALIGN_CHECK_EN
   logic [31:0] n_cells;
   logic [31:0] addr_lo32;
   logic        misalign;
   logic        err_q;

   assign n_cells   = size_to_count(32'(size));
   assign addr_lo32 = 32'(addr_lo);
   assign misalign  = ((addr_lo32 % n_cells) != 32'd0) ||
                      ((addr_lo32 + n_cells) > 32'(NUM_CELLS));
   assign accept    = seq_ready & ~misalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= seq_ready & (we | re) & misalign;
   end
   assign err = err_q;
`else
   assign accept = seq_ready;
   assign err    = 1'b0;
`endif

   // A simultaneous read is dropped in favour of the write.
   assign wr_fire = accept & we;
   assign rd_fire = accept & re & ~we;

   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_en[i]) rd_data_d[i*CELL_SIZE +: CELL_SIZE] = mem_q[lane_idx[i]];
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_idx] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) mem_q[lane_idx[i]] <= data_bus_in[i*CELL_SIZE +: CELL_SIZE];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) rd_data_q <= rd_data_d;
      end
   end

   assign data_bus_out = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign ready        = seq_ready;
   assign busy         = ~seq_ready;

endmodule
`default_nettype wire

// File: tb/tb_multicell_mem.sv
`default_nettype none
// ============================================================================
// tb_multicell_mem : table + scoreboard bench for multicell_mem (LOG2_CELLS=8)
// Revision: 1.0
// ============================================================================
module tb_multicell_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr_bus;
   logic [1:0]  size;
   logic [31:0] data_bus_in;
   logic        we;
   logic        re;
   logic [31:0] data_bus_out;
   logic        rd_valid;
   logic        ready;
   logic        busy;
   logic        err;

   multicell_mem #(
      .LOG2_CELLS (8),
      .ADDR_SIZE  (32),
      .CELL_SIZE  (8),
      .LANES      (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .addr_bus     (addr_bus),
      .size         (size),
      .data_bus_in  (data_bus_in),
      .we           (we),
      .re           (re),
      .data_bus_out (data_bus_out),
      .rd_valid     (rd_valid),
      .ready        (ready),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [1:0]  s;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } sb_t;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   err_due  = -1;
   sb_t  sb[$];
   vec_t tbl[14];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: each read is due one cycle after it is driven.
   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("rd_valid", {31'd0, rd_valid}, 32'd1);
            chk("rd_data", data_bus_out, sb[0].data);
            void'(sb.pop_front());
         end else if (rd_valid) begin
            chk("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
         end
         if (err || err_due == cyc) chk("err", {31'd0, err}, {31'd0, err_due == cyc});
         if (err && rd_valid) chk("err_rd_excl", 32'd1, 32'd0);
      end
   end

   task automatic do_req(input logic w, input logic r, input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] d, input logic [31:0] exp, input bit push,
                         input bit exp_err);
      @(negedge clk);
      we = w; re = r; addr_bus = a; size = s; data_bus_in = d;
      if (push) sb.push_back('{exp, cyc + 1});
      if (exp_err) err_due = cyc + 1;
   endtask

   task automatic idle();
      @(negedge clk);
      we = 1'b0; re = 1'b0;
   endtask

   task automatic count_clear();
      int n;
      n = 0;
      while (!ready && n < 400) begin
         @(posedge clk); n++; #1;
         // Requests issued mid-clear must neither write nor read.
         we = (n == 5); re = (n == 6);
         addr_bus = 32'h40; size = 2'd0; data_bus_in = 32'hAB;
         if (!ready && !busy) chk("busy_vs_ready", 32'd0, 32'd1);
      end
      we = 1'b0; re = 1'b0;
      chk("clear_len", n, 256);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] prev;
      tbl[0]  = '{1'b0, 1'b1, 32'h00,       2'd3, 32'h0,        32'h00000000};
      tbl[1]  = '{1'b0, 1'b1, 32'h40,       2'd3, 32'h0,        32'h00000000};
      tbl[2]  = '{1'b1, 1'b0, 32'h10,       2'd3, 32'hDDCCBBAA, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 32'h10,       2'd3, 32'h0,        32'hDDCCBBAA};
      tbl[4]  = '{1'b0, 1'b1, 32'h12,       2'd1, 32'h0,        32'h0000DDCC};
      tbl[5]  = '{1'b0, 1'b1, 32'h13,       2'd0, 32'h0,        32'h000000DD};
      tbl[6]  = '{1'b1, 1'b0, 32'h30,       2'd1, 32'h00001234, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, 32'h30,       2'd1, 32'h0,        32'h00001234};
      tbl[8]  = '{1'b1, 1'b0, 32'h40,       2'd0, 32'hFFFFFF77, 32'h0};
      tbl[9]  = '{1'b1, 1'b0, 32'h42,       2'd1, 32'h00009988, 32'h0};
      tbl[10] = '{1'b0, 1'b1, 32'h40,       2'd3, 32'h0,        32'h99880077};
      tbl[11] = '{1'b1, 1'b0, 32'h18,       2'd2, 32'hAABBCCDD, 32'h0};
      tbl[12] = '{1'b0, 1'b1, 32'h18,       2'd3, 32'h0,        32'h00BBCCDD};
      tbl[13] = '{1'b0, 1'b1, 32'hFFFFFF10, 2'd3, 32'h0,        32'hDDCCBBAA};

      rst = 1'b1; we = 1'b0; re = 1'b0; addr_bus = '0; size = '0; data_bus_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_data", data_bus_out, 32'd0);

      @(negedge clk); rst = 1'b0;
      count_clear();

      for (int i = 0; i < 14; i++) begin
         do_req(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].exp,
                tbl[i].r && !tbl[i].w, 1'b0);
      end
      idle();
      repeat (2) @(negedge clk);

      // Access straddling the top cell.
`ifdef MULTICELL_MEM_ALIGN_CHECK_EN
      do_req(1'b1, 1'b0, 32'hFF, 2'd1, 32'h2211, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 1'b1, 32'hFF, 2'd0, 32'h0, 32'h00000000, 1'b1, 1'b0);
      do_req(1'b0, 1'b1, 32'h00, 2'd0, 32'h0, 32'h00000000, 1'b1, 1'b0);
      do_req(1'b0, 1'b1, 32'hFF, 2'd1, 32'h0, 32'h0, 1'b0, 1'b1);
`else
      do_req(1'b1, 1'b0, 32'hFF, 2'd1, 32'h2211, 32'h0, 1'b0, 1'b0);
      do_req(1'b0, 1'b1, 32'hFF, 2'd0, 32'h0, 32'h00000011, 1'b1, 1'b0);
      do_req(1'b0, 1'b1, 32'h00, 2'd0, 32'h0, 32'h00000022, 1'b1, 1'b0);
      do_req(1'b0, 1'b1, 32'hFF, 2'd1, 32'h0, 32'h00002211, 1'b1, 1'b0);
`endif
      idle();
      repeat (2) @(negedge clk);

      // Write and read together: write wins, output register holds.
      prev = data_bus_out;
      do_req(1'b1, 1'b1, 32'h20, 2'd0, 32'h55, 32'h0, 1'b0, 1'b0);
      idle();
      chk("we_re_hold", data_bus_out, prev);
      do_req(1'b0, 1'b1, 32'h20, 2'd0, 32'h0, 32'h00000055, 1'b1, 1'b0);
      idle();
      repeat (2) @(negedge clk);

      // Reset landing in the cycle a read completes.
      @(negedge clk);
      re = 1'b1; addr_bus = 32'h10; size = 2'd3;
      @(posedge clk); #1;
      re = 1'b0;
      chk("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("pre_rst_data", data_bus_out, 32'hDDCCBBAA);
      #1 rst = 1'b1;
      #1;
      chk("async_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("async_data", data_bus_out, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Reset again partway through the clear; it must restart from cell 0.
      repeat (100) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midclr_ready", {31'd0, ready}, 32'd0);
      chk("midclr_busy", {31'd0, busy}, 32'd1);
      @(negedge clk); rst = 1'b0;
      count_clear();

      do_req(1'b0, 1'b1, 32'h10, 2'd3, 32'h0, 32'h00000000, 1'b1, 1'b0);
      do_req(1'b0, 1'b1, 32'h30, 2'd1, 32'h0, 32'h00000000, 1'b1, 1'b0);
      do_req(1'b0, 1'b1, 32'h40, 2'd3, 32'h0, 32'h00000000, 1'b1, 1'b0);
      idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
